ddr2_app_sequencer: RTL and testbench
=====================================

DDR2_APP_SEQUENCER -- requirements
Module: ddr2_app_sequencer

Interface
REQ-001 SHALL have parameter APPDATA_WIDTH, default 128: width of one MIG user-interface data beat.
REQ-002 SHALL have parameter RD_TIMEOUT, default 255: maximum cycles spent in RD_WAIT before abort (range 2..65535).
REQ-003 clk0  in  1  sole clock; all logic on its rising edge.
REQ-004 rst0  in  1  synchronous reset, active-high.
REQ-005 phy_init_done  in  1  MIG calibration complete; no commands are issued while low.
REQ-006 usr_req  in  1  user request strobe.
REQ-007 usr_we  in  1  1 = write, 0 = read; qualified by usr_req.
REQ-008 usr_addr  in  31  user address; bits [1:0] ignored.
REQ-009 usr_wdata  in  2*APPDATA_WIDTH  full burst-4 write data; lower half is beat 0.
REQ-010 usr_wmask  in  2*APPDATA_WIDTH/8  byte mask (1 = masked); lower half is beat 0.
REQ-011 usr_ready  out  1  request accepted on an edge where usr_req && usr_ready.
REQ-012 usr_rdata  out  2*APPDATA_WIDTH  assembled read burst; lower half is beat 0.
REQ-013 usr_rvalid  out  1  one-cycle pulse; usr_rdata is valid.
REQ-014 usr_rd_timeout  out  1  sticky read-timeout flag.
REQ-015 app_af_afull, app_wdf_afull  in  1 each  MIG address and data FIFO almost-full flags.
REQ-016 app_af_wren, app_af_cmd[2:0], app_af_addr[30:0]  out  MIG address FIFO write; cmd 3'b000 = write, 3'b001 = read.
REQ-017 app_wdf_wren, app_wdf_data[APPDATA_WIDTH-1:0], app_wdf_mask_data[APPDATA_WIDTH/8-1:0]  out  MIG write-data FIFO.
REQ-018 rd_data_valid, rd_data_fifo_out[APPDATA_WIDTH-1:0]  in  MIG read-return beats.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 The FSM SHALL have exactly these states: IDLE, WR_A, WR_B, RD_A, RD_WAIT.
REQ-021 usr_ready SHALL be 1 only when state is IDLE, phy_init_done = 1 and rst0 = 0; it SHALL be a registered output.
REQ-022 On acceptance, the block SHALL latch usr_we, {usr_addr[30:2],2'b00}, usr_wdata and usr_wmask, then go to WR_A if usr_we = 1, else RD_A.
REQ-023 In WR_A, on an edge with app_af_afull = 0 and app_wdf_afull = 0: set app_af_wren = 1, app_af_cmd = 000, app_af_addr = latched address, app_wdf_wren = 1, data/mask = beat 0, and go to WR_B; otherwise hold with both wren = 0.
REQ-024 In WR_B, on an edge with app_wdf_afull = 0: set app_wdf_wren = 1 with beat 1 and app_af_wren = 0, and go to IDLE; otherwise both wren = 0 and hold.
REQ-025 An accepted write SHALL therefore produce exactly one address-FIFO write and exactly two consecutive-or-stalled data-FIFO writes, in beat order; the data write SHALL never precede the address write.
REQ-026 In RD_A, on an edge with app_af_afull = 0: set app_af_wren = 1, app_af_cmd = 001 and the address, clear the beat count and timeout counter, and go to RD_WAIT.
REQ-027 In RD_WAIT, each rd_data_valid = 1 SHALL capture rd_data_fifo_out: the first into the lower half of usr_rdata, the second into the upper half.
REQ-028 On the second beat, usr_rvalid SHALL be 1 for the next cycle only, and the state SHALL return to IDLE.
REQ-029 In RD_WAIT, a 16-bit timeout counter SHALL increment every cycle; when it reaches RD_TIMEOUT, the block SHALL set usr_rd_timeout = 1, return to IDLE, and not pulse usr_rvalid.
REQ-030 rd_data_valid SHALL be ignored in every state except RD_WAIT.
REQ-031 app_af_wren and app_wdf_wren SHALL never be high for more than one cycle per beat.
REQ-032 If phy_init_done falls while not in IDLE, the current operation SHALL complete; only new acceptance is blocked.
REQ-033 usr_rdata SHALL hold its value until the next read completes.

Reset
REQ-034 While rst0 = 1, on each edge the block SHALL set: state = IDLE; usr_ready, usr_rvalid, usr_rd_timeout, app_af_wren and app_wdf_wren = 0; app_af_cmd = 000; all address, data, mask and usr_rdata registers = 0; counters = 0.
REQ-035 A reset asserted mid-operation SHALL abort that operation with no further FIFO writes; MIG recovery is the system's responsibility.
REQ-036 usr_rd_timeout SHALL be cleared only by rst0.

Verification
REQ-037 Write, both FIFOs empty: usr_addr = 0x40 -> app_af_wren with cmd 000 and addr 0x40 one cycle after acceptance, same cycle as the wdf beat 0, next cycle wdf beat 1, usr_ready high again 3 cycles after acceptance.
REQ-038 Write with app_wdf_afull held high 5 cycles during WR_B -> no app_wdf_wren during the stall; beat 1 issued the cycle after release; exactly 2 wdf writes total.
REQ-039 Read of 0x83 -> app_af_addr = 0x80, cmd 001; return beats A then B (gap of 3 cycles) -> usr_rdata = {B,A}, usr_rvalid pulsed for exactly one cycle.
REQ-040 Read with no return and RD_TIMEOUT = 10 -> usr_rd_timeout set 10 cycles after entering RD_WAIT; usr_rvalid never set; next request accepted normally.
REQ-041 phy_init_done = 0 with usr_req held -> usr_ready = 0 and no MIG writes; raise phy_init_done -> accepted on the following edge.
REQ-042 rst0 pulsed in WR_B -> no further wren after the reset edge; all outputs at their reset values.

Source files
------------

// File: rtl/ddr2_app_sequencer.sv
// Single-request sequencer between a simple user port and the MIG DDR2 user interface.
// States: IDLE accept | WR_A addr+beat0 | WR_B beat1 | RD_A read cmd | RD_WAIT collect beats or time out
module ddr2_app_sequencer #(
  parameter int APPDATA_WIDTH = 128,
  parameter int RD_TIMEOUT    = 255
) (
  input  logic                          clk0,
  input  logic                          rst0,
  input  logic                          phy_init_done,
  input  logic                          usr_req,
  input  logic                          usr_we,
  input  logic [30:0]                   usr_addr,
  input  logic [2*APPDATA_WIDTH-1:0]    usr_wdata,
  input  logic [2*APPDATA_WIDTH/8-1:0]  usr_wmask,
  output logic                          usr_ready,
  output logic [2*APPDATA_WIDTH-1:0]    usr_rdata,
  output logic                          usr_rvalid,
  output logic                          usr_rd_timeout,
  input  logic                          app_af_afull,
  input  logic                          app_wdf_afull,
  output logic                          app_af_wren,
  output logic [2:0]                    app_af_cmd,
  output logic [30:0]                   app_af_addr,
  output logic                          app_wdf_wren,
  output logic [APPDATA_WIDTH-1:0]      app_wdf_data,
  output logic [APPDATA_WIDTH/8-1:0]    app_wdf_mask_data,
  input  logic                          rd_data_valid,
  input  logic [APPDATA_WIDTH-1:0]      rd_data_fifo_out
);

  localparam int W  = APPDATA_WIDTH;
  localparam int DW = 2 * APPDATA_WIDTH;
  localparam int BW = APPDATA_WIDTH / 8;
  localparam int MW = 2 * BW;
  localparam logic [15:0] TIMEOUT_TC = 16'(RD_TIMEOUT);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_A, RD_WAIT} state_t;

  state_t          state_q, state_d;
  logic            usr_ready_q, usr_ready_d;
  logic            usr_rvalid_q, usr_rvalid_d;
  logic            usr_rd_timeout_q, usr_rd_timeout_d;
  logic [DW-1:0]   usr_rdata_q, usr_rdata_d;
  logic            app_af_wren_q, app_af_wren_d;
  logic [2:0]      app_af_cmd_q, app_af_cmd_d;
  logic [30:0]     app_af_addr_q, app_af_addr_d;
  logic            app_wdf_wren_q, app_wdf_wren_d;
  logic [W-1:0]    app_wdf_data_q, app_wdf_data_d;
  logic [BW-1:0]   app_wdf_mask_q, app_wdf_mask_d;
  logic [30:0]     addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   wmask_q, wmask_d;
  logic            beat_q, beat_d;
  logic [15:0]     tmo_q, tmo_d;
  logic            accept;

  assign accept = usr_req && usr_ready_q;

  always_comb begin
    state_d          = state_q;
    usr_rvalid_d     = 1'b0;
    usr_rd_timeout_d = usr_rd_timeout_q;
    usr_rdata_d      = usr_rdata_q;
    app_af_wren_d    = 1'b0;
    app_af_cmd_d     = app_af_cmd_q;
    app_af_addr_d    = app_af_addr_q;
    app_wdf_wren_d   = 1'b0;
    app_wdf_data_d   = app_wdf_data_q;
    app_wdf_mask_d   = app_wdf_mask_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    wmask_d          = wmask_q;
    beat_d           = beat_q;
    tmo_d            = tmo_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = {usr_addr[30:2], 2'b00};
          wdata_d = usr_wdata;
          wmask_d = usr_wmask;
          state_d = usr_we ? WR_A : RD_A;
        end
      end
      WR_A: begin
        // Address and beat 0 go out together so data never leads its command.
        if (!app_af_afull && !app_wdf_afull) begin
          app_af_wren_d  = 1'b1;
          app_af_cmd_d   = 3'b000;
          app_af_addr_d  = addr_q;
          app_wdf_wren_d = 1'b1;
          app_wdf_data_d = wdata_q[W-1:0];
          app_wdf_mask_d = wmask_q[BW-1:0];
          state_d        = WR_B;
        end
      end
      WR_B: begin
        if (!app_wdf_afull) begin
          app_wdf_wren_d = 1'b1;
          app_wdf_data_d = wdata_q[DW-1:W];
          app_wdf_mask_d = wmask_q[MW-1:BW];
          state_d        = IDLE;
        end
      end
      RD_A: begin
        if (!app_af_afull) begin
          app_af_wren_d = 1'b1;
          app_af_cmd_d  = 3'b001;
          app_af_addr_d = addr_q;
          beat_d        = 1'b0;
          tmo_d         = 16'd0;
          state_d       = RD_WAIT;
        end
      end
      RD_WAIT: begin
        tmo_d = tmo_q + 16'd1;
        if (rd_data_valid) begin
          if (!beat_q) begin
            usr_rdata_d[W-1:0] = rd_data_fifo_out;
            beat_d             = 1'b1;
          end else begin
            usr_rdata_d[DW-1:W] = rd_data_fifo_out;
            usr_rvalid_d        = 1'b1;
            state_d             = IDLE;
          end
        end
        // A completing second beat wins over a coincident timeout.
        if (!(rd_data_valid && beat_q) && (tmo_d == TIMEOUT_TC)) begin
          usr_rd_timeout_d = 1'b1;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    usr_ready_d = (state_q == IDLE) && phy_init_done && !accept;
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q          <= IDLE;
      usr_ready_q      <= 1'b0;
      usr_rvalid_q     <= 1'b0;
      usr_rd_timeout_q <= 1'b0;
      usr_rdata_q      <= '0;
      app_af_wren_q    <= 1'b0;
      app_af_cmd_q     <= 3'b000;
      app_af_addr_q    <= '0;
      app_wdf_wren_q   <= 1'b0;
      app_wdf_data_q   <= '0;
      app_wdf_mask_q   <= '0;
      addr_q           <= '0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      beat_q           <= 1'b0;
      tmo_q            <= '0;
    end else begin
      state_q          <= state_d;
      usr_ready_q      <= usr_ready_d;
      usr_rvalid_q     <= usr_rvalid_d;
      usr_rd_timeout_q <= usr_rd_timeout_d;
      usr_rdata_q      <= usr_rdata_d;
      app_af_wren_q    <= app_af_wren_d;
      app_af_cmd_q     <= app_af_cmd_d;
      app_af_addr_q    <= app_af_addr_d;
      app_wdf_wren_q   <= app_wdf_wren_d;
      app_wdf_data_q   <= app_wdf_data_d;
      app_wdf_mask_q   <= app_wdf_mask_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      wmask_q          <= wmask_d;
      beat_q           <= beat_d;
      tmo_q            <= tmo_d;
    end
  end

  assign usr_ready         = usr_ready_q;
  assign usr_rvalid        = usr_rvalid_q;
  assign usr_rd_timeout    = usr_rd_timeout_q;
  assign usr_rdata         = usr_rdata_q;
  assign app_af_wren       = app_af_wren_q;
  assign app_af_cmd        = app_af_cmd_q;
  assign app_af_addr       = app_af_addr_q;
  assign app_wdf_wren      = app_wdf_wren_q;
  assign app_wdf_data      = app_wdf_data_q;
  assign app_wdf_mask_data = app_wdf_mask_q;

endmodule

// File: tb/tb_ddr2_app_sequencer.sv
// Bench for ddr2_app_sequencer: transaction-level scoreboard checked every cycle,
// plus directed scenarios with hand-computed cycle-exact expectations.
module tb_ddr2_app_sequencer;

  localparam int W  = 128;
  localparam int DW = 256;
  localparam int TO = 10;

  localparam logic [127:0] WD1_LO = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] WD1_HI = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  localparam logic [127:0] WD2_LO = 128'h13579bdf_2468ace0_fedcba98_76543210;
  localparam logic [127:0] WD2_HI = 128'hcafef00d_12345678_9abcdef0_0badc0de;
  localparam logic [127:0] RA     = 128'haaaa0001_aaaa0002_aaaa0003_aaaa0004;
  localparam logic [127:0] RB     = 128'hbbbb0001_bbbb0002_bbbb0003_bbbb0004;

  logic            clk0 = 1'b0;
  logic            rst0, phy_init_done, usr_req, usr_we;
  logic [30:0]     usr_addr;
  logic [DW-1:0]   usr_wdata;
  logic [DW/8-1:0] usr_wmask;
  logic            usr_ready, usr_rvalid, usr_rd_timeout;
  logic [DW-1:0]   usr_rdata;
  logic            app_af_afull, app_wdf_afull;
  logic            app_af_wren, app_wdf_wren;
  logic [2:0]      app_af_cmd;
  logic [30:0]     app_af_addr;
  logic [W-1:0]    app_wdf_data;
  logic [W/8-1:0]  app_wdf_mask_data;
  logic            rd_data_valid;
  logic [W-1:0]    rd_data_fifo_out;

  always #5 clk0 = ~clk0;

  ddr2_app_sequencer #(.APPDATA_WIDTH(W), .RD_TIMEOUT(TO)) dut (
    .clk0(clk0), .rst0(rst0), .phy_init_done(phy_init_done),
    .usr_req(usr_req), .usr_we(usr_we), .usr_addr(usr_addr),
    .usr_wdata(usr_wdata), .usr_wmask(usr_wmask),
    .usr_ready(usr_ready), .usr_rdata(usr_rdata), .usr_rvalid(usr_rvalid),
    .usr_rd_timeout(usr_rd_timeout),
    .app_af_afull(app_af_afull), .app_wdf_afull(app_wdf_afull),
    .app_af_wren(app_af_wren), .app_af_cmd(app_af_cmd), .app_af_addr(app_af_addr),
    .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
    .app_wdf_mask_data(app_wdf_mask_data),
    .rd_data_valid(rd_data_valid), .rd_data_fifo_out(rd_data_fifo_out)
  );

  int n_vec = 0;
  int n_bad = 0;
  int wdf_total = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk0);
    #1;
  endtask

  // Scoreboard: expected FIFO writes per accepted request, read return model, timeout model.
  logic [33:0]   af_q[$];
  logic [143:0]  wdf_q[$];
  logic [33:0]   af_e;
  logic [143:0]  wdf_e;
  logic          busy = 1'b0, rd_active = 1'b0, wr_addr_issued = 1'b0;
  logic          exp_rvalid_next = 1'b0, exp_timeout = 1'b0;
  logic [255:0]  model_rdata = '0, exp_rdata = '0;
  int            rd_k = 0, rd_beats = 0, wr_beats = 0;
  logic          prev_rst = 1'b1, prev_phy = 1'b0, prev_af_afull = 1'b0, prev_wdf_afull = 1'b0;

  initial begin
    forever begin
      @(negedge clk0);
      if (prev_rst) begin
        chk("rst_ctrl", {usr_ready, usr_rvalid, usr_rd_timeout, app_af_wren, app_wdf_wren, app_af_cmd}, 0);
        chk("rst_af_addr", app_af_addr, 0);
        chk("rst_wdf", {app_wdf_mask_data, app_wdf_data}, 0);
        chk("rst_rdata", usr_rdata, 0);
        af_q.delete();
        wdf_q.delete();
        busy = 0; rd_active = 0; wr_addr_issued = 0; wr_beats = 0;
        exp_rvalid_next = 0; exp_timeout = 0; model_rdata = '0;
      end else begin
        chk("ready_while_busy_or_uncal", usr_ready & (busy | ~prev_phy), 0);
        chk("rvalid", usr_rvalid, exp_rvalid_next);
        if (exp_rvalid_next) chk("rdata", usr_rdata, exp_rdata);
        chk("rd_timeout", usr_rd_timeout, exp_timeout);
        exp_rvalid_next = 0;
        chk("af_while_afull", app_af_wren & prev_af_afull, 0);
        chk("wr_af_while_wdf_afull", app_af_wren & (app_af_cmd == 3'b000) & prev_wdf_afull, 0);
        chk("wdf_while_afull", app_wdf_wren & prev_wdf_afull, 0);
        if (app_af_wren) begin
          if (af_q.size() == 0) chk("af_unexpected", app_af_wren, 0);
          else begin
            af_e = af_q.pop_front();
            chk("af_cmd_addr", {app_af_cmd, app_af_addr}, af_e);
            if (af_e[33:31] == 3'b001) begin
              rd_active = 1; rd_k = 0; rd_beats = 0;
            end else wr_addr_issued = 1;
          end
        end
        chk("wdf_before_af", app_wdf_wren & ~wr_addr_issued, 0);
        if (app_wdf_wren) begin
          wdf_total++;
          if (wdf_q.size() == 0) chk("wdf_unexpected", app_wdf_wren, 0);
          else begin
            wdf_e = wdf_q.pop_front();
            chk("wdf_beat", {app_wdf_mask_data, app_wdf_data}, wdf_e);
            wr_beats++;
            if (wr_beats == 2) begin
              busy = 0; wr_addr_issued = 0; wr_beats = 0;
            end
          end
        end
        if (rd_active) begin
          if (rd_data_valid && rd_beats == 0) begin
            model_rdata[127:0] = rd_data_fifo_out;
            rd_beats = 1;
          end else if (rd_data_valid) begin
            model_rdata[255:128] = rd_data_fifo_out;
            exp_rdata = model_rdata;
            exp_rvalid_next = 1;
            rd_active = 0;
            busy = 0;
          end
          if (rd_active && (rd_k + 1 == TO)) begin
            exp_timeout = 1;
            rd_active = 0;
            busy = 0;
          end
          rd_k++;
        end
        if (usr_req && usr_ready && !rst0) begin
          busy = 1;
          if (usr_we) begin
            af_q.push_back({3'b000, usr_addr[30:2], 2'b00});
            wdf_q.push_back({usr_wmask[15:0], usr_wdata[127:0]});
            wdf_q.push_back({usr_wmask[31:16], usr_wdata[255:128]});
          end else begin
            af_q.push_back({3'b001, usr_addr[30:2], 2'b00});
          end
        end
      end
      prev_rst       = rst0;
      prev_phy       = phy_init_done;
      prev_af_afull  = app_af_afull;
      prev_wdf_afull = app_wdf_afull;
    end
  end

  int w0;

  initial begin
    rst0 = 1; phy_init_done = 0; usr_req = 0; usr_we = 0; usr_addr = '0;
    usr_wdata = '0; usr_wmask = '0; app_af_afull = 0; app_wdf_afull = 0;
    rd_data_valid = 0; rd_data_fifo_out = '0;
    repeat (3) cyc();
    @(negedge clk0);
    chk("reset_ready", usr_ready, 0);
    chk("reset_wren", {app_af_wren, app_wdf_wren}, 0);
    cyc(); rst0 = 0; phy_init_done = 1;
    cyc(); @(negedge clk0);
    chk("ready_after_reset", usr_ready, 1);

    // Write to 0x40, both FIFOs free
    cyc(); usr_req = 1; usr_we = 1; usr_addr = 31'h40; usr_wdata = {WD1_HI, WD1_LO}; usr_wmask = 32'hA5A5_0F0F;
    cyc(); usr_req = 0;
    @(negedge clk0);
    chk("wr_ready_drop", usr_ready, 0);
    chk("wr_no_early_af", app_af_wren, 0);
    cyc(); @(negedge clk0);
    chk("wr_af_wren", app_af_wren, 1);
    chk("wr_af_cmd", app_af_cmd, 3'b000);
    chk("wr_af_addr", app_af_addr, 31'h40);
    chk("wr_beat0_wren", app_wdf_wren, 1);
    chk("wr_beat0_data", app_wdf_data, WD1_LO);
    chk("wr_beat0_mask", app_wdf_mask_data, 16'h0F0F);
    cyc(); @(negedge clk0);
    chk("wr_af_single", app_af_wren, 0);
    chk("wr_beat1_wren", app_wdf_wren, 1);
    chk("wr_beat1_data", app_wdf_data, WD1_HI);
    chk("wr_beat1_mask", app_wdf_mask_data, 16'hA5A5);
    chk("wr_ready_still_low", usr_ready, 0);
    cyc(); @(negedge clk0);
    chk("wr_ready_back_3cyc", usr_ready, 1);
    chk("wr_wdf_done", app_wdf_wren, 0);

    // Write with the data FIFO stalled for 5 cycles in WR_B
    cyc(); usr_req = 1; usr_addr = 31'h100; usr_wdata = {WD2_HI, WD2_LO}; usr_wmask = '0;
    cyc(); usr_req = 0; w0 = wdf_total;
    cyc(); app_wdf_afull = 1;
    @(negedge clk0);
    chk("stall_beat0", app_wdf_wren, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 4) app_wdf_afull = 0;
      @(negedge clk0);
      chk("stall_no_wdf", app_wdf_wren, 0);
    end
    cyc(); @(negedge clk0);
    chk("stall_beat1_wren", app_wdf_wren, 1);
    chk("stall_beat1_data", app_wdf_data, WD2_HI);
    cyc(); @(negedge clk0);
    chk("stall_wdf_count", 32'(wdf_total - w0), 2);

    // Read of 0x83, beats A then B with a 3-cycle gap
    cyc(); usr_req = 1; usr_we = 0; usr_addr = 31'h83;
    cyc(); usr_req = 0;
    cyc(); rd_data_valid = 1; rd_data_fifo_out = RA;
    @(negedge clk0);
    chk("rd_af_wren", app_af_wren, 1);
    chk("rd_af_cmd", app_af_cmd, 3'b001);
    chk("rd_af_addr", app_af_addr, 31'h80);
    cyc(); rd_data_valid = 0; rd_data_fifo_out = '0;
    @(negedge clk0);
    chk("rd_no_early_rvalid", usr_rvalid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) begin rd_data_valid = 1; rd_data_fifo_out = RB; end
      @(negedge clk0);
      chk("rd_gap_rvalid", usr_rvalid, 0);
    end
    cyc(); rd_data_valid = 0; rd_data_fifo_out = '0;
    @(negedge clk0);
    chk("rd_rvalid_pulse", usr_rvalid, 1);
    chk("rd_rdata", usr_rdata, {RB, RA});
    cyc(); @(negedge clk0);
    chk("rd_rvalid_one_cycle", usr_rvalid, 0);
    chk("rd_rdata_hold", usr_rdata, {RB, RA});

    // Read of 0x200 with no return: times out after TO cycles in RD_WAIT
    cyc(); usr_req = 1; usr_addr = 31'h200;
    cyc(); usr_req = 0;
    cyc(); @(negedge clk0);
    chk("to_af_wren", app_af_wren, 1);
    for (int i = 1; i < TO; i++) begin
      cyc(); @(negedge clk0);
      chk("to_not_yet", usr_rd_timeout, 0);
    end
    cyc(); @(negedge clk0);
    chk("to_flag_set", usr_rd_timeout, 1);
    chk("to_no_rvalid", usr_rvalid, 0);
    cyc(); rd_data_valid = 1; rd_data_fifo_out = 128'hdead;
    cyc(); cyc(); rd_data_valid = 0; rd_data_fifo_out = '0;
    @(negedge clk0);
    chk("idle_beats_ignored", usr_rdata, {RB, RA});
    chk("to_flag_sticky", usr_rd_timeout, 1);
    cyc(); usr_req = 1; usr_we = 1; usr_addr = 31'h23; usr_wdata = {WD1_HI, WD1_LO}; usr_wmask = 32'h0000_FFFF;
    cyc(); usr_req = 0;
    cyc(); @(negedge clk0);
    chk("after_to_af_addr", {app_af_wren, app_af_addr}, {1'b1, 31'h20});
    cyc(); cyc();

    // Calibration low blocks acceptance; in-flight op completes after it drops again
    cyc(); phy_init_done = 0;
    cyc(); usr_req = 1; usr_we = 1; usr_addr = 31'h300; usr_wdata = {WD2_HI, WD2_LO}; usr_wmask = 32'hFFFF_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk0);
      chk("uncal_ready", usr_ready, 0);
      chk("uncal_no_mig", {app_af_wren, app_wdf_wren}, 0);
      cyc();
    end
    phy_init_done = 1;
    @(negedge clk0);
    chk("uncal_ready_lag", usr_ready, 0);
    cyc(); @(negedge clk0);
    chk("cal_ready_rise", usr_ready, 1);
    cyc(); usr_req = 0; phy_init_done = 0;
    @(negedge clk0);
    chk("cal_accepted", usr_ready, 0);
    cyc(); @(negedge clk0);
    chk("cal_af", {app_af_wren, app_af_addr}, {1'b1, 31'h300});
    chk("cal_beat0", app_wdf_wren, 1);
    cyc(); @(negedge clk0);
    chk("cal_beat1_mask", {app_wdf_wren, app_wdf_mask_data}, {1'b1, 16'hFFFF});
    cyc(); @(negedge clk0);
    chk("cal_af_q_empty", 32'(af_q.size()), 0);
    chk("cal_wdf_q_empty", 32'(wdf_q.size()), 0);
    cyc(); phy_init_done = 1;
    cyc(); cyc();

    // Reset pulsed while in WR_B
    cyc(); usr_req = 1; usr_addr = 31'h400; usr_wdata = {WD1_HI, WD1_LO}; usr_wmask = '0;
    cyc(); usr_req = 0;
    cyc(); rst0 = 1;
    @(negedge clk0);
    chk("rst_mid_beat0", {app_wdf_wren, app_wdf_data}, {1'b1, WD1_LO});
    cyc(); rst0 = 0;
    @(negedge clk0);
    chk("rst_mid_wren", {app_af_wren, app_wdf_wren}, 0);
    chk("rst_mid_timeout_clr", usr_rd_timeout, 0);
    chk("rst_mid_rdata", usr_rdata, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk0);
      chk("rst_mid_no_wren", {app_af_wren, app_wdf_wren}, 0);
    end
    chk("rst_mid_ready_back", usr_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
